// File: rtl/video_board_pkg.sv
// Shared types and constants for the video DRAM readout serializer.
// Optional feature macro used by the readout: VIDEO_READOUT_HFLIP_EN
// (horizontal flip through HF_AL).
package video_board_pkg;

  localparam int PIXELS_PER_WORD = 4;
  localparam int COUNT_W         = 3;

  // One output pixel, ordered {R,G,B,Z}.
  typedef logic [3:0] pixel_t;

  // Readout sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    STARVE = 2'd2
  } state_e;

  // One DRAM read word: four planes, bit n of each plane belongs to pixel n.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] z;
  } dram_word_t;

  localparam logic [COUNT_W-1:0] RST_COUNT  = '0;
  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(PIXELS_PER_WORD - 1);
  localparam pixel_t             RST_PIXEL  = 4'h0;
  localparam dram_word_t         RST_WORD   = '0;
  localparam logic [7:0]         RST_DB     = 8'h00;

endpackage

// File: rtl/video_pixel_select.sv
// Pixel index generation and bit pick out of the shifter word.
// With VIDEO_READOUT_HFLIP_EN defined, HF_AL=0 mirrors the pixel order
// inside a word; without it the order is always ascending and HF_AL is unused.
module video_pixel_select
  import video_board_pkg::*;
(
  input  dram_word_t word,
  input  logic [1:0] count,
  input  logic       hf_al,
  output pixel_t     pixel
);

  logic [1:0] index;

`ifdef VIDEO_READOUT_HFLIP_EN
  assign index = hf_al ? count : (2'd3 - count);
`else
  logic unused_hf_al;
  assign unused_hf_al = hf_al;
  assign index        = count;
`endif

  assign pixel = {word.r[index], word.g[index], word.b[index], word.z[index]};

endmodule

// File: rtl/video_dynamic_ram_readout_serializer.sv
// Video DRAM readout serializer: double-buffers 4-pixel DRAM words
// (hold -> shifter), emits one {R,G,B,Z} pixel per PIX_EN, flags starvation
// and overruns in a sticky UNDERRUN, and serves CPU byte readback of the
// DRAM planes during EXCT cycles.
// Optional feature macro: VIDEO_READOUT_HFLIP_EN (horizontal flip via HF_AL).
module video_dynamic_ram_readout_serializer
  import video_board_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       PIX_EN,
  input  logic       LOAD,
  input  logic [3:0] DXR,
  input  logic [3:0] DXG,
  input  logic [3:0] DXB,
  input  logic [3:0] DXZ,
  input  logic       EN,
  input  logic       HF_AL,
  input  logic       EXCT,
  input  logic       RD_STB,
  input  logic       PLANE_SEL,
  output pixel_t     PIX_RGBZ,
  output logic       PIX_VALID,
  output logic       UNDERRUN,
  output logic [7:0] DB_OUT,
  output logic       RD_ACK
);

  state_e               state_q, state_d;
  dram_word_t           hold_q, shift_q, dx_word;
  logic                 hold_valid_q;
  logic [COUNT_W-1:0]   count_q;
  logic                 load_ok, rd_ok, word_end;
  logic                 take_hold, take_direct, advance;
  logic                 starve_enter, overwrite, pix_active;
  pixel_t               pixel;

  // A CPU access cycle owns the DX bus, so display loads are blocked then.
  assign load_ok  = LOAD && !EXCT;
  assign rd_ok    = RD_STB && EXCT;
  assign dx_word  = '{r: DXR, g: DXG, b: DXB, z: DXZ};
  assign word_end = PIX_EN && (count_q == LAST_COUNT);

  // State register.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a word in hold starts or resumes shifting; running
  // off the end of a word with nothing queued and no coinciding load starves.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (hold_valid_q) state_d = SHIFT;
      SHIFT:   if (word_end && !hold_valid_q && !load_ok) state_d = STARVE;
      STARVE:  if (hold_valid_q) state_d = SHIFT;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs of the sequencer for the datapath below.
  always_comb begin
    take_hold    = 1'b0;
    take_direct  = 1'b0;
    advance      = 1'b0;
    starve_enter = 1'b0;
    pix_active   = 1'b0;
    case (state_q)
      IDLE, STARVE: take_hold = hold_valid_q;
      SHIFT: begin
        pix_active = 1'b1;
        if (PIX_EN) begin
          if (count_q != LAST_COUNT) advance      = 1'b1;
          else if (hold_valid_q)     take_hold    = 1'b1;
          // Load arriving exactly at the word boundary with hold empty goes
          // straight to the shifter so the pixel stream stays contiguous.
          else if (load_ok)          take_direct  = 1'b1;
          else                       starve_enter = 1'b1;
        end
      end
      default: ;
    endcase
    // A queued word replaced before it was ever consumed is lost data.
    overwrite = load_ok && hold_valid_q && !take_hold;
  end

  // Hold/shift datapath, pixel counter and sticky underrun flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: hold and shifter contents are reset too, so a word in flight
      // at reset can never reach the pixel output afterwards.
      hold_q       <= RST_WORD;
      hold_valid_q <= 1'b0;
      shift_q      <= RST_WORD;
      count_q      <= RST_COUNT;
      UNDERRUN     <= 1'b0;
    end else begin
      if (take_hold)        shift_q <= hold_q;
      else if (take_direct) shift_q <= dx_word;

      if (take_hold || take_direct) count_q <= RST_COUNT;
      else if (advance)             count_q <= count_q + 3'd1;

      // A load during a hold->shifter transfer refills hold, keeping order.
      if (load_ok && !take_direct) begin
        hold_q       <= dx_word;
        hold_valid_q <= 1'b1;
      end else if (take_hold) begin
        hold_valid_q <= 1'b0;
      end

      if (starve_enter || overwrite) UNDERRUN <= 1'b1;
    end
  end

  video_pixel_select u_pixel_select (
    .word  (shift_q),
    .count (count_q[1:0]),
    .hf_al (HF_AL),
    .pixel (pixel)
  );

  // Registered pixel output; blanked when the layer is off or not shifting.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PIX_RGBZ  <= RST_PIXEL;
      PIX_VALID <= 1'b0;
    end else begin
      PIX_RGBZ  <= (EN && pix_active) ? pixel : RST_PIXEL;
      PIX_VALID <= EN && pix_active;
    end
  end

  // CPU readback of a plane pair with a one-cycle acknowledge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DB_OUT <= RST_DB;
      RD_ACK <= 1'b0;
    end else begin
      if (rd_ok) DB_OUT <= PLANE_SEL ? {DXZ, DXR} : {DXG, DXB};
      RD_ACK <= rd_ok;
    end
  end

endmodule

// File: tb/tb_video_dynamic_ram_readout_serializer.sv
// Directed self-checking bench for video_dynamic_ram_readout_serializer.
// Expected pixel order depends on VIDEO_READOUT_HFLIP_EN for the HF_AL=0 case.
module tb_video_dynamic_ram_readout_serializer;
  import video_board_pkg::*;

  logic       CLK = 1'b0;
  logic       RST, PIX_EN, LOAD, EN, HF_AL, EXCT, RD_STB, PLANE_SEL;
  logic [3:0] DXR, DXG, DXB, DXZ;
  logic [3:0] PIX_RGBZ;
  logic       PIX_VALID, UNDERRUN, RD_ACK;
  logic [7:0] DB_OUT;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_flip [4];
  logic [3:0] exp_a    [4];
  logic [3:0] exp_ab   [8];

  always #5 CLK = ~CLK;

  video_dynamic_ram_readout_serializer dut (
    .CLK       (CLK),
    .RST       (RST),
    .PIX_EN    (PIX_EN),
    .LOAD      (LOAD),
    .DXR       (DXR),
    .DXG       (DXG),
    .DXB       (DXB),
    .DXZ       (DXZ),
    .EN        (EN),
    .HF_AL     (HF_AL),
    .EXCT      (EXCT),
    .RD_STB    (RD_STB),
    .PLANE_SEL (PLANE_SEL),
    .PIX_RGBZ  (PIX_RGBZ),
    .PIX_VALID (PIX_VALID),
    .UNDERRUN  (UNDERRUN),
    .DB_OUT    (DB_OUT),
    .RD_ACK    (RD_ACK)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    LOAD = 1'b0; PIX_EN = 1'b0; RD_STB = 1'b0; EXCT = 1'b0; PLANE_SEL = 1'b0;
    DXR = 4'h0; DXG = 4'h0; DXB = 4'h0; DXZ = 4'h0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    tick();
    RST = 1'b0;
  endtask

  task automatic load_word(input logic [3:0] r, input logic [3:0] g,
                           input logic [3:0] b, input logic [3:0] z);
    LOAD = 1'b1; DXR = r; DXG = g; DXB = b; DXZ = z;
    tick();
    LOAD = 1'b0; DXR = 4'h0; DXG = 4'h0; DXB = 4'h0; DXZ = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Word A = DXR 0001 -> pixels 8,0,0,0 ascending.
    exp_a  = '{4'h8, 4'h0, 4'h0, 4'h0};
`ifdef VIDEO_READOUT_HFLIP_EN
    exp_flip = '{4'h0, 4'h0, 4'h0, 4'h8};
`else
    exp_flip = '{4'h8, 4'h0, 4'h0, 4'h0};
`endif
    // Word A then word B (DXG 0110, DXZ 1001 -> 1,4,4,1).
    exp_ab = '{4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h4, 4'h4, 4'h1};

    EN = 1'b1; HF_AL = 1'b1;

    // Reset state.
    do_reset();
    check("rst_rgbz",  PIX_RGBZ,    4'h0);
    check("rst_valid", PIX_VALID,   1'b0);
    check("rst_under", UNDERRUN,    1'b0);
    check("rst_db",    DB_OUT,      8'h00);
    check("rst_ack",   RD_ACK,      1'b0);
    check("rst_state", dut.state_q, IDLE);

    // Single word, ascending order, six pixel enables: starves after pixel 4.
    load_word(4'b0001, 4'h0, 4'h0, 4'h0);
    tick();
    PIX_EN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 4) begin
        check($sformatf("asc_pix%0d", i),   PIX_RGBZ,  exp_a[i]);
        check($sformatf("asc_valid%0d", i), PIX_VALID, 1'b1);
      end else begin
        check($sformatf("starve_valid%0d", i), PIX_VALID, 1'b0);
        check($sformatf("starve_rgbz%0d", i),  PIX_RGBZ,  4'h0);
      end
    end
    check("starve_under", UNDERRUN, 1'b1);
    PIX_EN = 1'b0;
    load_word(4'b0001, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    check("recover_valid",  PIX_VALID, 1'b1);
    check("under_sticky",   UNDERRUN,  1'b1);

    // Same word with HF_AL=0: mirrored only when the flip feature is built in.
    do_reset();
    check("rst2_under", UNDERRUN, 1'b0);
    HF_AL = 1'b0;
    load_word(4'b0001, 4'h0, 4'h0, 4'h0);
    tick();
    PIX_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("flip_pix%0d", i), PIX_RGBZ, exp_flip[i]);
    end
    HF_AL = 1'b1;

    // Back-to-back words, second load coincides with count=3: 8 contiguous pixels.
    do_reset();
    load_word(4'b0001, 4'h0, 4'h0, 4'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      PIX_EN = (i != 7);
      if (i == 3) begin
        LOAD = 1'b1; DXG = 4'b0110; DXZ = 4'b1001;
      end else begin
        LOAD = 1'b0; DXG = 4'h0; DXZ = 4'h0;
      end
      tick();
      check($sformatf("b2b_pix%0d", i),   PIX_RGBZ,  exp_ab[i]);
      check($sformatf("b2b_valid%0d", i), PIX_VALID, 1'b1);
    end
    idle_inputs();
    check("b2b_under", UNDERRUN, 1'b0);

    // EN=0 blanks output while shifting continues (DXB 1100 -> 0,0,2,2).
    do_reset();
    EN = 1'b0;
    load_word(4'h0, 4'h0, 4'b1100, 4'h0);
    tick();
    PIX_EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      EN = (i >= 2);
      tick();
      if (i < 2) begin
        check($sformatf("en0_rgbz%0d", i),  PIX_RGBZ,  4'h0);
        check($sformatf("en0_valid%0d", i), PIX_VALID, 1'b0);
      end else begin
        check($sformatf("en1_rgbz%0d", i),  PIX_RGBZ,  4'h2);
        check($sformatf("en1_valid%0d", i), PIX_VALID, 1'b1);
      end
    end
    EN = 1'b1;

    // CPU readback: Z/R pair, LOAD in the same cycle ignored.
    do_reset();
    EXCT = 1'b1; RD_STB = 1'b1; PLANE_SEL = 1'b1; LOAD = 1'b1;
    DXZ = 4'hA; DXR = 4'h5; DXG = 4'h7; DXB = 4'h3;
    tick();
    check("rd_db_zr",    DB_OUT,           8'hA5);
    check("rd_ack",      RD_ACK,           1'b1);
    check("rd_noload",   dut.hold_valid_q, 1'b0);
    idle_inputs();
    tick();
    check("rd_ack_drop", RD_ACK, 1'b0);
    check("rd_db_hold",  DB_OUT, 8'hA5);
    tick();
    check("rd_nopix",    PIX_VALID,   1'b0);
    check("rd_idle",     dut.state_q, IDLE);
    RD_STB = 1'b1; PLANE_SEL = 1'b0; DXG = 4'h3; DXB = 4'hC;
    tick();
    check("rd_noexct_db",  DB_OUT, 8'hA5);
    check("rd_noexct_ack", RD_ACK, 1'b0);
    EXCT = 1'b1;
    tick();
    check("rd_db_gb",  DB_OUT, 8'h3C);
    check("rd_ack_gb", RD_ACK, 1'b1);
    idle_inputs();

    // Reset mid-SHIFT with overrun flagged, a read registered and a load in flight.
    do_reset();
    EXCT = 1'b1; RD_STB = 1'b1; DXG = 4'hF; DXB = 4'hF;
    tick();
    idle_inputs();
    load_word(4'b0001, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    check("mid_valid", PIX_VALID, 1'b1);
    check("mid_rgbz",  PIX_RGBZ,  4'h8);
    load_word(4'hF, 4'h0, 4'h0, 4'h0);
    load_word(4'h0, 4'hF, 4'h0, 4'h0);
    check("overwrite_under", UNDERRUN, 1'b1);
    RST = 1'b1; LOAD = 1'b1; PIX_EN = 1'b1; DXR = 4'hF;
    tick();
    check("mrst_rgbz",  PIX_RGBZ,         4'h0);
    check("mrst_valid", PIX_VALID,        1'b0);
    check("mrst_under", UNDERRUN,         1'b0);
    check("mrst_db",    DB_OUT,           8'h00);
    check("mrst_ack",   RD_ACK,           1'b0);
    check("mrst_state", dut.state_q,      IDLE);
    check("mrst_hold",  dut.hold_valid_q, 1'b0);
    RST = 1'b0;
    idle_inputs();
    PIX_EN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid%0d", i), PIX_VALID, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_dynamic_ram_readout_serializer.md
VIDEO_DYNAMIC_RAM_READOUT_SERIALIZER -- requirements
Module: video_dynamic_ram_readout_serializer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single video clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port PIX_EN, input, 1 bit: pixel-advance qualifier.
REQ-004 SHALL have port LOAD, input, 1 bit: DRAM read word valid on DXR/DXG/DXB/DXZ.
REQ-005 SHALL have ports DXR, DXG, DXB, DXZ, input, 4 bits each: DRAM read planes, bit n = pixel n.
REQ-006 SHALL have ports EN and HF_AL, input, 1 bit each: layer enable; horizontal flip, active low.
REQ-007 SHALL have ports EXCT and RD_STB, input, 1 bit each: CPU access cycle; CPU read strobe.
REQ-008 SHALL have port PLANE_SEL, input, 1 bit: readback pair, 0 = G/B, 1 = Z/R.
REQ-009 SHALL have port PIX_RGBZ, output, 4 bits: current pixel as {R,G,B,Z}.
REQ-010 SHALL have port PIX_VALID, output, 1 bit: PIX_RGBZ carries shifted data.
REQ-011 SHALL have port UNDERRUN, output, 1 bit: sticky starvation flag.
REQ-012 SHALL have ports DB_OUT, output, 8 bits, and RD_ACK, output, 1 bit: CPU readback byte and its one-cycle acknowledge.

Function
REQ-013 SHALL keep a hold register (16 bits plus HOLD_VALID) and a shift register (16 bits plus 3-bit pixel counter).
REQ-014 SHALL, when LOAD=1 and EXCT=0, capture the DX planes into the hold register and set HOLD_VALID.
REQ-015 SHALL ignore LOAD while EXCT=1.
REQ-016 SHALL implement a state machine with states IDLE, SHIFT and STARVE.
REQ-017 SHALL, in IDLE with HOLD_VALID=1, transfer hold to shifter, clear HOLD_VALID, set count=0 and enter SHIFT in the same cycle.
REQ-018 SHALL, in SHIFT on each PIX_EN, advance count by one.
REQ-019 SHALL, at count=3 with PIX_EN, reload from hold if HOLD_VALID (stay in SHIFT, count=0) or else enter STARVE.
REQ-020 SHALL let a LOAD coinciding with that reload win: the new word goes directly to the shifter and is not lost.
REQ-021 SHALL, in STARVE, set UNDERRUN and drive PIX_VALID=0, then go to SHIFT on the next HOLD_VALID.
REQ-022 SHALL, when a LOAD arrives with HOLD_VALID=1 and no transfer that cycle, overwrite hold (newest data wins) and also set UNDERRUN.
REQ-023 SHALL select the output pixel as index=count when HF_AL=1 and index=3-count when HF_AL=0; PIX_RGBZ = {DXR[i],DXG[i],DXB[i],DXZ[i]} of the shifter.
REQ-024 SHALL register PIX_RGBZ/PIX_VALID, with a latency of one CLK from the count change.
REQ-025 SHALL force PIX_RGBZ=4'h0 and PIX_VALID=0 when EN=0; the shifting continues.
REQ-026 SHALL, on RD_STB=1 with EXCT=1, register DB_OUT={DXG,DXB} when PLANE_SEL=0 or {DXZ,DXR} when PLANE_SEL=1, and pulse RD_ACK the next cycle.
REQ-027 SHALL ignore RD_STB while EXCT=0, and hold DB_OUT until the next accepted read.
REQ-028 SHALL clear UNDERRUN only on RST.

Reset
REQ-029 SHALL, on RST, go to IDLE with count=0, HOLD_VALID=0, shifter=0, PIX_RGBZ=0, PIX_VALID=0, UNDERRUN=0, DB_OUT=8'h00 and RD_ACK=0.
REQ-030 SHALL give RST priority over LOAD, PIX_EN and RD_STB in the same cycle; a word in flight is discarded.

Configuration
REQ-031 SHALL, with VIDEO_READOUT_HFLIP_EN defined, honour HF_AL as REQ-023.
REQ-032 SHALL, without VIDEO_READOUT_HFLIP_EN, use index=count always and leave HF_AL unused.

Structure
REQ-033 SHALL place the state enum, the 4-bit pixel typedef, PIXELS_PER_WORD=4 and the reset constants in the shared package video_board_pkg.
REQ-034 SHALL implement the pixel index and bit pick as one sub-module, video_pixel_select.

Verification
REQ-035 SHALL check: LOAD DXR=4'b0001, others 0, HF_AL=1, four PIX_EN -> PIX_RGBZ 4'b1000, 0, 0, 0.
REQ-036 SHALL check: the same word with HF_AL=0 -> 0, 0, 0, 4'b1000; without the macro, the order is unchanged.
REQ-037 SHALL check: back-to-back LOADs with the second coinciding with count=3 -> 8 contiguous valid pixels and UNDERRUN=0.
REQ-038 SHALL check: a single LOAD then 6 PIX_EN -> PIX_VALID drops after pixel 4 and UNDERRUN=1 until RST.
REQ-039 SHALL check: EXCT=1, RD_STB, PLANE_SEL=1, DXZ=4'hA, DXR=4'h5 -> DB_OUT=8'hA5 with RD_ACK one cycle later; a LOAD in that cycle is ignored.
REQ-040 SHALL check: RST asserted mid-SHIFT -> all outputs at reset values next cycle, IDLE, and the prior word is not output.
